mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through, runs loads/stores as a
// level request (IDLE -> REQ -> REL) and retires one writeback pulse per op.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_sdata,
  output logic        stall_req,
  output logic        mm_e,
  output logic [31:0] mm_a,
  output logic [31:0] mm_n_i,
  output logic        mm_wr,
  output logic [1:0]  mm_cu,
  input  logic        mm_ok,
  input  logic [31:0] mm_n_o,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic        store_q, store_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    load_ext = {{24{d[7]}}, d[7:0]};
      3'd1:    load_ext = {{16{d[15]}}, d[15:0]};
      3'd4:    load_ext = {24'd0, d[7:0]};
      3'd5:    load_ext = {16'd0, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  function automatic logic [1:0] byte_cnt(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: byte_cnt = 2'd0;
      3'd1, 3'd5: byte_cnt = 2'd1;
      default:    byte_cnt = 2'd3;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    store_d    = store_q;
    rdata_d    = rdata_q;
    wb_valid_d = 1'b0;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (ex_load || ex_store) begin
            // A still-high mm_ok belongs to the previous transfer; wait it out.
            if (!mm_ok) begin
              funct3_d = ex_funct3;
              rd_d     = ex_rd;
              addr_d   = ex_alu;
              sdata_d  = ex_sdata;
              store_d  = ex_store;
              state_d  = S_REQ;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu;
          end
        end
      end
      S_REQ: begin
        if (mm_ok) begin
          rdata_d = mm_n_o;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (!mm_ok) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (store_q) begin
            wb_we_d   = 1'b0;
            wb_data_d = 32'd0;
          end else begin
            wb_we_d   = (rd_q != 5'd0);
            wb_data_d = load_ext(funct3_q, rdata_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      funct3_q   <= 3'd0;
      rd_q       <= 5'd0;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      store_q    <= 1'b0;
      rdata_q    <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      store_q    <= store_d;
      rdata_q    <= rdata_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign stall_req = (state_q != S_IDLE);
  assign mm_e      = (state_q == S_REQ);
  assign mm_a      = addr_q;
  assign mm_n_i    = sdata_q;
  assign mm_wr     = store_q;
  assign mm_cu     = byte_cnt(funct3_q);
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule
